// File: rtl/nv_nvdla_bdma_mcif_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nv_nvdla_bdma_mcif_responder
// Memory-side endpoint for the BDMA mcif read and write ports, backed by a
// single-port synchronous SRAM.
//   - Read requests are split into per-atom SRAM reads. Beats are returned
//     through a 2-entry output buffer and are throttled by a latency-FIFO
//     credit counter.
//   - Write command packets open a burst. The data packets that follow are
//     written straight into the SRAM. If the command asked for an ack, a
//     one-cycle completion pulse follows the last beat.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn    clock, async active-low reset
//   bdma2mcif_rd_req_*                  read request (addr, size)
//   mcif2bdma_rd_rsp_*                  256-bit read beats, mask bit always 1
//   bdma2mcif_rd_cdt_lat_fifo_pop       one credit returned per high cycle
//   bdma2mcif_wr_req_*                  write cmd/data packets, [257] = pkt id
//   mcif2bdma_wr_rsp_complete           write completion pulse
//   mem_*                               SRAM port (read data 1 cycle later)
// -----------------------------------------------------------------------------
module nv_nvdla_bdma_mcif_responder #(
    parameter int MEM_AW    = 10,
    parameter int LAT_DEPTH = 8
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              bdma2mcif_rd_req_valid,
    output logic              bdma2mcif_rd_req_ready,
    input  logic [78:0]       bdma2mcif_rd_req_pd,
    output logic              mcif2bdma_rd_rsp_valid,
    input  logic              mcif2bdma_rd_rsp_ready,
    output logic [256:0]      mcif2bdma_rd_rsp_pd,
    input  logic              bdma2mcif_rd_cdt_lat_fifo_pop,
    input  logic              bdma2mcif_wr_req_valid,
    output logic              bdma2mcif_wr_req_ready,
    input  logic [257:0]      bdma2mcif_wr_req_pd,
    output logic              mcif2bdma_wr_rsp_complete,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [255:0]      mem_wdata,
    input  logic [255:0]      mem_rdata
);
    localparam int CW = $clog2(LAT_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD     = 2'd1,
        S_WR_CMD = 2'd2,
        S_WR_DAT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MEM_AW-1:0]   r_addr;
    logic [15:0]         r_cnt;
    logic                r_ack;
    logic                r_cmpl;
    logic                r_alive;
    logic                r_inflight;
    logic [CW-1:0]       r_credit;
    logic [CW-1:0]       w_credit_inc;
    logic [255:0]        r_fifo_mem [2];
    logic                r_wp;
    logic                r_rp;
    logic [1:0]          r_fcnt;
    logic [1:0]          w_occ;
    logic                w_is_data;
    logic                w_rd_acc;
    logic                w_wr_cmd_acc;
    logic                w_wr_dat_acc;
    logic                w_rd_issue;
    logic                w_last;
    logic                w_push;
    logic                w_pop;
    logic                w_unused_bits;

    // Handshakes are decoded from state and valids, not from the ready outputs,
    // so no combinational path loops back through the output logic. r_alive
    // keeps every ready low while reset is asserted and for the first cycle after.
    assign w_is_data    = bdma2mcif_wr_req_pd[257];
    assign w_rd_acc     = r_alive && (r_state == S_IDLE) && bdma2mcif_rd_req_valid
                          && !bdma2mcif_wr_req_valid;
    assign w_wr_cmd_acc = r_alive && (r_state == S_IDLE) && bdma2mcif_wr_req_valid
                          && !w_is_data;
    assign w_wr_dat_acc = (r_state == S_WR_DAT) && bdma2mcif_wr_req_valid && w_is_data;
    assign w_last       = (r_cnt == 16'd1);

    // Keep at most two beats between issue and the consumer: buffered plus in flight.
    assign w_occ        = r_fcnt + {1'b0, r_inflight};
    assign w_rd_issue   = (r_state == S_RD) && (r_credit < CW'(LAT_DEPTH)) && (w_occ < 2'd2);
    assign w_credit_inc = r_credit + {{(CW-1){1'b0}}, w_rd_issue};

    assign w_push       = r_inflight;
    assign w_pop        = (r_fcnt != 2'd0) && mcif2bdma_rd_rsp_ready;

    assign mcif2bdma_rd_rsp_valid    = (r_fcnt != 2'd0);
    assign mcif2bdma_rd_rsp_pd       = mcif2bdma_rd_rsp_valid ? {1'b1, r_fifo_mem[r_rp]} : 257'd0;
    assign mcif2bdma_wr_rsp_complete = r_cmpl;

    // Address bits below the atom and above the SRAM range, plus the write mask,
    // have no effect on this endpoint.
    assign w_unused_bits = ^{bdma2mcif_rd_req_pd[63:MEM_AW+5], bdma2mcif_rd_req_pd[4:0],
                             bdma2mcif_wr_req_pd[256]};

    // State register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode. A write has priority in IDLE. A data packet seen in IDLE is dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = w_wr_cmd_acc ? S_WR_DAT : (w_rd_acc ? S_RD : S_IDLE);
            S_RD:     w_state_nxt = (w_rd_issue && w_last) ? S_IDLE : S_RD;
            S_WR_DAT: w_state_nxt = (w_wr_dat_acc && w_last) ? S_IDLE : S_WR_DAT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: request readies and the SRAM port.
    always_comb begin
        bdma2mcif_rd_req_ready = 1'b0;
        bdma2mcif_wr_req_ready = 1'b0;
        mem_en                 = 1'b0;
        mem_we                 = 1'b0;
        mem_addr               = {MEM_AW{1'b0}};
        mem_wdata              = 256'd0;
        case (r_state)
            S_IDLE: begin
                bdma2mcif_rd_req_ready = r_alive && !bdma2mcif_wr_req_valid;
                bdma2mcif_wr_req_ready = r_alive;
            end
            S_RD: begin
                mem_en   = w_rd_issue;
                mem_addr = w_rd_issue ? r_addr : {MEM_AW{1'b0}};
            end
            S_WR_DAT: begin
                // A new command packet is held off until the current burst ends.
                bdma2mcif_wr_req_ready = w_is_data;
                mem_en    = w_wr_dat_acc;
                mem_we    = w_wr_dat_acc;
                mem_addr  = w_wr_dat_acc ? r_addr : {MEM_AW{1'b0}};
                mem_wdata = w_wr_dat_acc ? bdma2mcif_wr_req_pd[255:0] : 256'd0;
            end
            default: begin
                bdma2mcif_rd_req_ready = 1'b0;
            end
        endcase
    end

    // Transfer bookkeeping: word address, beats remaining, ack flag, completion pulse.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_addr  <= {MEM_AW{1'b0}};
            r_cnt   <= 16'd0;
            r_ack   <= 1'b0;
            r_cmpl  <= 1'b0;
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_cmpl  <= w_wr_dat_acc && w_last && r_ack;
            if (w_wr_cmd_acc) begin
                r_addr <= bdma2mcif_wr_req_pd[MEM_AW+4:5];
                r_cnt  <= {3'd0, bdma2mcif_wr_req_pd[76:64]} + 16'd1;
                r_ack  <= bdma2mcif_wr_req_pd[77];
            end else if (w_rd_acc) begin
                r_addr <= bdma2mcif_rd_req_pd[MEM_AW+4:5];
                r_cnt  <= {1'b0, bdma2mcif_rd_req_pd[78:64]} + 16'd1;
            end else if (w_rd_issue || w_wr_dat_acc) begin
                r_addr <= r_addr + MEM_AW'(1);
                r_cnt  <= r_cnt - 16'd1;
            end else begin
                r_addr <= r_addr;
            end
        end
    end

    // Credit counter. An issue and a pop in the same cycle cancel out. A pop at zero saturates.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_credit <= {CW{1'b0}};
        end else if (bdma2mcif_rd_cdt_lat_fifo_pop && (w_credit_inc != {CW{1'b0}})) begin
            r_credit <= w_credit_inc - CW'(1);
        end else begin
            r_credit <= w_credit_inc;
        end
    end

    // Two-entry read output buffer, loaded with SRAM data one cycle after each issue.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_inflight    <= 1'b0;
            r_wp          <= 1'b0;
            r_rp          <= 1'b0;
            r_fcnt        <= 2'd0;
            r_fifo_mem[0] <= 256'd0;
            r_fifo_mem[1] <= 256'd0;
        end else begin
            r_inflight <= w_rd_issue;
            r_fcnt     <= r_fcnt + {1'b0, w_push} - {1'b0, w_pop};
            r_rp       <= w_pop ? ~r_rp : r_rp;
            if (w_push) begin
                r_fifo_mem[r_wp] <= mem_rdata;
                r_wp             <= ~r_wp;
            end else begin
                r_wp <= r_wp;
            end
        end
    end

endmodule

// File: tb/tb_nv_nvdla_bdma_mcif_responder.sv
`timescale 1ns/1ps
module tb_nv_nvdla_bdma_mcif_responder;
    localparam int AW = 10;
    localparam int LD = 8;
    localparam int NW = 1 << AW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           rd_valid = 1'b0;
    logic           rd_ready;
    logic [78:0]    rd_pd = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [256:0]   rsp_pd;
    logic           cdt_pop;
    logic           wr_valid = 1'b0;
    logic           wr_ready;
    logic [257:0]   wr_pd = '0;
    logic           complete;
    logic           mem_en;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [255:0]   mem_wdata;
    logic [255:0]   mem_rdata = '0;

    logic           auto_pop = 1'b0;
    logic           manual_pop = 1'b0;
    int             checks = 0;
    int             failures = 0;

    logic [255:0]   sram    [NW];
    logic [255:0]   ref_mem [NW];
    logic [256:0]   got_q [$];
    int             issue_cnt = 0;
    int             wr_cnt = 0;
    int             cmpl_cnt = 0;

    always #5 clk = ~clk;

    assign cdt_pop = auto_pop ? (rsp_valid && rsp_ready) : manual_pop;

    nv_nvdla_bdma_mcif_responder #(.MEM_AW(AW), .LAT_DEPTH(LD)) dut (
        .nvdla_core_clk               (clk),
        .nvdla_core_rstn              (rst_n),
        .bdma2mcif_rd_req_valid       (rd_valid),
        .bdma2mcif_rd_req_ready       (rd_ready),
        .bdma2mcif_rd_req_pd          (rd_pd),
        .mcif2bdma_rd_rsp_valid       (rsp_valid),
        .mcif2bdma_rd_rsp_ready       (rsp_ready),
        .mcif2bdma_rd_rsp_pd          (rsp_pd),
        .bdma2mcif_rd_cdt_lat_fifo_pop(cdt_pop),
        .bdma2mcif_wr_req_valid       (wr_valid),
        .bdma2mcif_wr_req_ready       (wr_ready),
        .bdma2mcif_wr_req_pd          (wr_pd),
        .mcif2bdma_wr_rsp_complete    (complete),
        .mem_en                       (mem_en),
        .mem_we                       (mem_we),
        .mem_addr                     (mem_addr),
        .mem_wdata                    (mem_wdata),
        .mem_rdata                    (mem_rdata)
    );

    // Synchronous single-port SRAM model.
    always @(posedge clk) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
    end

    // Monitor: collect delivered beats and count SRAM traffic and completions.
    always @(posedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) got_q.push_back(rsp_pd);
            if (mem_en && !mem_we) issue_cnt <= issue_cnt + 1;
            if (mem_en && mem_we) wr_cnt <= wr_cnt + 1;
            if (complete) cmpl_cnt <= cmpl_cnt + 1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_wr(input logic [257:0] pd, output bit ok);
        bit fire;
        ok = 1'b0;
        wr_valid = 1'b1;
        wr_pd = pd;
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            fire = wr_ready;
            tick();
            if (fire) ok = 1'b1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic send_rd(input logic [63:0] addr, input int size, output bit ok);
        bit fire;
        logic [14:0] sz;
        sz = size[14:0];
        ok = 1'b0;
        rd_valid = 1'b1;
        rd_pd = {sz, addr};
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            fire = rd_ready;
            tick();
            if (fire) ok = 1'b1;
        end
        rd_valid = 1'b0;
    endtask

    // Writes size+1 random beats starting at a word and updates the reference image.
    // c0/c1: completion output right after the last beat is accepted, and one cycle later.
    task automatic do_write(input int word, input int size, input bit ack,
                            output bit ok, output logic c0, output logic c1);
        logic [257:0] pd;
        logic [255:0] d;
        logic [9:0]   w10;
        logic [12:0]  s13;
        bit           okb;
        w10 = word[9:0];
        s13 = size[12:0];
        pd = '0;
        pd[63:0] = {$urandom, $urandom};
        pd[14:5] = w10;
        pd[76:64] = s13;
        pd[77] = ack;
        send_wr(pd, ok);
        c0 = 1'b0;
        c1 = 1'b0;
        for (int i = 0; i <= size; i++) begin
            d = rand256();
            repeat ($urandom_range(0, 2)) tick();
            pd = '0;
            pd[255:0] = d;
            pd[256] = $urandom_range(0, 1);
            pd[257] = 1'b1;
            send_wr(pd, okb);
            ok = ok && okb;
            ref_mem[(word + i) % NW] = d;
        end
        c0 = complete;
        tick();
        c1 = complete;
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (got_q.size() >= n) ok = 1'b1;
            else tick();
        end
        if (got_q.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++; if (rd_ready !== 1'b0) begin failures++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got %b exp 0", wr_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if ({mem_en, mem_we, complete} !== 3'b000) begin failures++; $display("FAIL reset_misc got %b exp 000", {mem_en, mem_we, complete}); end
        checks++; if (rsp_pd !== 257'd0) begin failures++; $display("FAIL reset_rsp_pd got %h exp 0", rsp_pd); end
        rst_n = 1'b1;
        tick(); tick();
        checks++; if ({rd_ready, wr_ready} !== 2'b11) begin failures++; $display("FAIL idle_ready got %b exp 11", {rd_ready, wr_ready}); end
    endtask

    task automatic test_write_ack();
        bit ok;
        logic c0, c1;
        int cc, wc;
        cc = cmpl_cnt;
        do_write(2, 3, 1'b1, ok, c0, c1);
        checks++; if (!ok) begin failures++; $display("FAIL write_accept got 0 exp 1"); end
        checks++; if ({c0, c1} !== 2'b10) begin failures++; $display("FAIL write_ack_pulse got %b exp 10", {c0, c1}); end
        for (int w = 2; w <= 5; w++) begin
            checks++; if (sram[w] !== ref_mem[w]) begin failures++; $display("FAIL write_word %0d got %h exp %h", w, sram[w], ref_mem[w]); end
        end
        checks++; if (cmpl_cnt - cc !== 1) begin failures++; $display("FAIL write_ack_count got %0d exp 1", cmpl_cnt - cc); end
        // ack = 0 variant: no pulse at all
        cc = cmpl_cnt;
        do_write(2, 3, 1'b0, ok, c0, c1);
        repeat (3) tick();
        checks++; if (cmpl_cnt - cc !== 0 || c0 !== 1'b0) begin failures++; $display("FAIL write_noack_pulse got %0d exp 0", cmpl_cnt - cc); end
        checks++; if (sram[5] !== ref_mem[5]) begin failures++; $display("FAIL write_noack_data got %h exp %h", sram[5], ref_mem[5]); end
        // data packet in IDLE: accepted and dropped, no SRAM write
        wc = wr_cnt;
        send_wr({1'b1, 1'b0, rand256()}, ok);
        tick();
        checks++; if (!ok || wr_cnt !== wc) begin failures++; $display("FAIL stray_data got ok=%0d writes=%0d exp ok=1 writes=0", ok, wr_cnt - wc); end
        checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL stray_data_idle got %b exp 1", rd_ready); end
    endtask

    task automatic test_read_basic();
        int first;
        bit ok;
        logic [256:0] exp;
        got_q.delete();
        rsp_ready = 1'b1;
        auto_pop = 1'b1;
        first = 0;
        rd_valid = 1'b1;
        rd_pd = {15'd3, 64'h40};
        #1;
        checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL read_req_ready got %b exp 1", rd_ready); end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            if (cyc == 1) rd_valid = 1'b0;
            if (first == 0 && rsp_valid) first = cyc;
        end
        checks++; if (first != 3) begin failures++; $display("FAIL read_latency got %0d exp 3", first); end
        wait_rsp(4, 50, ok);
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, ref_mem[2 + i]};
            checks++; if (i >= got_q.size() || got_q[i] !== exp) begin failures++; $display("FAIL read_data beat %0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 257'd0, exp); end
        end
        repeat (4) tick();
    endtask

    task automatic test_credit();
        int base, i0;
        bit ok;
        logic c0, c1;
        logic [63:0] a;
        logic [256:0] exp;
        base = $urandom_range(0, NW - 1);
        do_write(base, 15, 1'b0, ok, c0, c1);
        got_q.delete();
        auto_pop = 1'b0;
        manual_pop = 1'b0;
        rsp_ready = 1'b1;
        i0 = issue_cnt;
        a = 64'(base) << 5;
        send_rd(a, 15, ok);
        repeat (40) tick();
        checks++; if (issue_cnt - i0 !== LD || got_q.size() != LD) begin failures++; $display("FAIL credit_stall got issued=%0d got=%0d exp %0d", issue_cnt - i0, got_q.size(), LD); end
        manual_pop = 1'b1; tick(); manual_pop = 1'b0;
        repeat (10) tick();
        checks++; if (issue_cnt - i0 !== LD + 1) begin failures++; $display("FAIL credit_one_pop got %0d exp %0d", issue_cnt - i0, LD + 1); end
        repeat (7) begin manual_pop = 1'b1; tick(); manual_pop = 1'b0; tick(); end
        repeat (20) tick();
        checks++; if (issue_cnt - i0 !== 16 || got_q.size() != 16) begin failures++; $display("FAIL credit_all got issued=%0d got=%0d exp 16", issue_cnt - i0, got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            exp = {1'b1, ref_mem[(base + i) % NW]};
            checks++; if (i >= got_q.size() || got_q[i] !== exp) begin failures++; $display("FAIL credit_data beat %0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 257'd0, exp); end
        end
        repeat (8) begin manual_pop = 1'b1; tick(); manual_pop = 1'b0; end
        tick();
    endtask

    task automatic test_backpressure();
        int base, i0, n;
        bit ok, pv, pr;
        logic c0, c1;
        logic [256:0] prev, exp;
        base = $urandom_range(0, NW - 1);
        do_write(base, 7, 1'b1, ok, c0, c1);
        got_q.delete();
        auto_pop = 1'b1;
        rsp_ready = 1'b0;
        i0 = issue_cnt;
        send_rd((64'($urandom) << 15) | (64'(base) << 5) | 64'($urandom_range(0, 31)), 7, ok);
        pv = 1'b0;
        prev = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (pv && rsp_valid) begin
                checks++; if (rsp_pd !== prev) begin failures++; $display("FAIL bp_stable got %h exp %h", rsp_pd, prev); end
            end
            pv = rsp_valid;
            prev = rsp_pd;
        end
        checks++; if (issue_cnt - i0 !== 2 || rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_buffered got issued=%0d valid=%b exp 2 1", issue_cnt - i0, rsp_valid); end
        n = 0;
        pv = rsp_valid; prev = rsp_pd; pr = 1'b0;
        while (got_q.size() < 8 && n < 300) begin
            rsp_ready = $urandom_range(0, 1);
            pr = rsp_ready;
            tick();
            n++;
            if (pv && !pr) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_pd !== prev) begin failures++; $display("FAIL bp_hold got %b %h exp 1 %h", rsp_valid, rsp_pd, prev); end
            end
            pv = rsp_valid; prev = rsp_pd;
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, ref_mem[(base + i) % NW]};
            checks++; if (i >= got_q.size() || got_q[i] !== exp) begin failures++; $display("FAIL bp_data beat %0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 257'd0, exp); end
        end
        repeat (4) tick();
    endtask

    task automatic test_priority();
        int base, i0;
        bit ok;
        logic [257:0] pd;
        logic [255:0] d [2];
        logic [9:0] w10;
        logic [256:0] exp;
        base = $urandom_range(0, NW - 1);
        w10 = base[9:0];
        got_q.delete();
        rsp_ready = 1'b1;
        auto_pop = 1'b1;
        i0 = issue_cnt;
        rd_valid = 1'b1;
        rd_pd = {15'd1, 49'd0, w10, 5'd0};
        pd = '0; pd[14:5] = w10; pd[76:64] = 13'd1; pd[77] = 1'b1;
        wr_valid = 1'b1; wr_pd = pd;
        #1;
        checks++; if ({rd_ready, wr_ready} !== 2'b01) begin failures++; $display("FAIL prio_ready got %b exp 01", {rd_ready, wr_ready}); end
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d[i] = rand256();
            ref_mem[(base + i) % NW] = d[i];
            send_wr({1'b1, 1'b0, d[i]}, ok);
        end
        checks++; if (issue_cnt - i0 !== 0) begin failures++; $display("FAIL prio_read_early got %0d exp 0", issue_cnt - i0); end
        for (int i = 0; i < 20 && rd_valid; i++) begin
            if (rd_ready) begin tick(); rd_valid = 1'b0; end
            else tick();
        end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL prio_read_accept got 0 exp 1"); end
        rd_valid = 1'b0;
        wait_rsp(2, 40, ok);
        for (int i = 0; i < 2; i++) begin
            exp = {1'b1, d[i]};
            checks++; if (i >= got_q.size() || got_q[i] !== exp) begin failures++; $display("FAIL prio_data beat %0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 257'd0, exp); end
        end
        repeat (4) tick();
    endtask

    task automatic test_wrap_random();
        bit ok;
        logic c0, c1;
        logic [256:0] exp;
        int base, size;
        bit ack;
        for (int t = 0; t < 7; t++) begin
            base = (t == 0) ? NW - 2 : $urandom_range(0, NW - 1);
            size = (t == 0) ? 3 : $urandom_range(0, 5);
            ack = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            do_write(base, size, ack, ok, c0, c1);
            checks++; if (!ok || c0 !== ack) begin failures++; $display("FAIL rnd_write t%0d got ok=%0d ack=%b exp 1 %b", t, ok, c0, ack); end
            got_q.delete();
            rsp_ready = 1'b1;
            auto_pop = 1'b1;
            send_rd((64'($urandom) << 15) | (64'(base) << 5) | 64'($urandom_range(0, 31)), size, ok);
            wait_rsp(size + 1, 80, ok);
            repeat (3) tick();
            checks++; if (got_q.size() != size + 1) begin failures++; $display("FAIL rnd_count t%0d got %0d exp %0d", t, got_q.size(), size + 1); end
            for (int i = 0; i <= size; i++) begin
                exp = {1'b1, ref_mem[(base + i) % NW]};
                checks++; if (i >= got_q.size() || got_q[i] !== exp) begin failures++; $display("FAIL rnd_data t%0d beat %0d got %h exp %h", t, i, (i < got_q.size()) ? got_q[i] : 257'd0, exp); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, i0;
        bit ok;
        logic c0, c1;
        logic [256:0] exp;
        base = $urandom_range(0, NW - 1);
        do_write(base, 15, 1'b0, ok, c0, c1);
        auto_pop = 1'b0;
        manual_pop = 1'b0;
        rsp_ready = 1'b0;
        send_rd(64'(base) << 5, 15, ok);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({rsp_valid, rd_ready, wr_ready, mem_en, complete} !== 5'b0) begin failures++; $display("FAIL mid_reset_outputs got %b exp 00000", {rsp_valid, rd_ready, wr_ready, mem_en, complete}); end
        checks++; if (rsp_pd !== 257'd0) begin failures++; $display("FAIL mid_reset_pd got %h exp 0", rsp_pd); end
        tick(); tick();
        rst_n = 1'b1;
        got_q.delete();
        rsp_ready = 1'b1;
        tick();
        i0 = issue_cnt;
        send_rd(64'(base) << 5, 15, ok);
        repeat (40) tick();
        checks++; if (issue_cnt - i0 !== LD || got_q.size() != LD) begin failures++; $display("FAIL post_reset_window got issued=%0d got=%0d exp %0d", issue_cnt - i0, got_q.size(), LD); end
        repeat (8) begin manual_pop = 1'b1; tick(); manual_pop = 1'b0; end
        repeat (30) tick();
        for (int i = 0; i < 16; i++) begin
            exp = {1'b1, ref_mem[(base + i) % NW]};
            checks++; if (i >= got_q.size() || got_q[i] !== exp) begin failures++; $display("FAIL post_reset_data beat %0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 257'd0, exp); end
        end
        repeat (8) begin manual_pop = 1'b1; tick(); manual_pop = 1'b0; end
        tick();
    endtask

    initial begin
        for (int w = 0; w < NW; w++) begin
            sram[w] = '0;
            ref_mem[w] = '0;
        end
        test_reset();
        test_write_ack();
        test_read_basic();
        test_credit();
        test_backpressure();
        test_priority();
        test_wrap_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
